// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding, grant
// encoding and the fixed-priority arbitration rule.
package mem_arb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_DM = 3'd2,
        ST_RESP_IF = 3'd3,
        ST_RESP_DM = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_e;

    // DM normally wins; a starved fetch overrides it.
    function automatic grant_e arbitrate(input logic if_req,
                                         input logic dm_req,
                                         input logic if_starved);
        if (dm_req && !(if_req && if_starved)) begin
            return GNT_DM;
        end
        if (if_req) begin
            return GNT_IF;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side (IF/DM) and memory-side signals of the unified-memory arbiter.
// The arbiter uses the slave view; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              bus_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_stall, dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata,
               bus_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_stall, dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata,
               bus_err
    );

endinterface

// File: rtl/mem_arb_wait_timer.sv
// Wait counter for a memory access in flight. tc fires in the cycle whose
// increment would bring the count to MAX_WAIT, i.e. the last allowed wait cycle.
module mem_arb_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q != CNT_W'(MAX_WAIT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign tc = en && (count_q == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data-memory accesses onto one single-port
// memory, stalls the losing port, bounds fetch starvation and flags timeouts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                bus_err_q, bus_err_d;

    logic   timer_clr;
    logic   timer_en;
    logic   timer_tc;
    logic   busy_if;
    grant_e grant;

    assign grant = arbitrate(bus.if_req, bus.dm_req,
                             starve_cnt_q == STARVE_W'(STARVE_LIMIT));

    mem_arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr),
        .en       (timer_en),
        .load     (1'b0),
        .load_val ('0),
        .tc       (timer_tc)
    );

    // mem_req/mem_we are derived from the next state so they are clean flops
    // that stay asserted for exactly the BUSY cycles.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        bus_err_d    = bus_err_q;
        timer_clr    = 1'b0;
        timer_en     = 1'b0;
        busy_if      = (state_q == ST_BUSY_IF);

        case (state_q)
            ST_IDLE: begin
                case (grant)
                    GNT_DM: begin
                        state_d      = ST_BUSY_DM;
                        hold_addr_d  = bus.dm_addr;
                        hold_wdata_d = bus.dm_wdata;
                        mem_req_d    = 1'b1;
                        mem_we_d     = bus.dm_we;
                        timer_clr    = 1'b1;
                        if (bus.if_req && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
                            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                        end
                    end
                    GNT_IF: begin
                        state_d      = ST_BUSY_IF;
                        hold_addr_d  = bus.if_addr;
                        hold_wdata_d = '0;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        timer_clr    = 1'b1;
                        starve_cnt_d = '0;
                    end
                    default: ;
                endcase
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                timer_en = !bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = busy_if ? ST_RESP_IF : ST_RESP_DM;
                    if (busy_if) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end else if (timer_tc) begin
                    state_d   = busy_if ? ST_RESP_IF : ST_RESP_DM;
                    bus_err_d = 1'b1;
                    if (busy_if) begin
                        if_rdata_d = '0;
                    end else begin
                        dm_rdata_d = '0;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            ST_RESP_IF, ST_RESP_DM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Stalls are gated by reset so every output reads 0 while reset is held.
    assign bus.if_stall  = reset && bus.if_req && (state_q != ST_RESP_IF);
    assign bus.dm_stall  = reset && bus.dm_req && (state_q != ST_RESP_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = hold_addr_q;
    assign bus.mem_wdata = hold_wdata_q;
    assign bus.bus_err   = bus_err_q;

endmodule
